decode_dispatch_queue: RTL and testbench

- Collects decoded micro-ops from the per-format instruction decoders (DS, D, X, …) and buffers them in an in-order queue.
- Issues the head entry to its target functional unit (FX, FP, LdSt, Branch, Trap) once that unit signals ready.
- Drives the shared stall back to fetch/decode so that the decoders' one-cycle registered latency never overflows the queue.
- Sits between the format decoders and the execution units; it is the decode stage's sequencer.

---
 rtl/decode_dispatch_queue_pkg.sv | 18 +
 rtl/decode_dispatch_queue_uop_fifo.sv | 42 ++++
 rtl/decode_dispatch_queue.sv | 112 +++++++++++
 tb/tb_decode_dispatch_queue.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/decode_dispatch_queue_pkg.sv
// dispatch_pkg: functional-unit codes and the micro-op record shared by decoders and the dispatch queue
package dispatch_pkg;
  localparam logic [2:0] FX     = 3'd0;
  localparam logic [2:0] FP     = 3'd1;
  localparam logic [2:0] LDST   = 3'd2;
  localparam logic [2:0] BRANCH = 3'd3;
  localparam logic [2:0] TRAP   = 3'd4;
  localparam int NUM_FU = 5;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 16;
  typedef struct packed {
    logic [REG_W-1:0] reg1;
    logic [REG_W-1:0] reg2;
    logic             reg2_zero;
    logic [IMM_W-1:0] imm;
    logic [2:0]       fu_code;
  } uop_t;
endpackage

// File: rtl/decode_dispatch_queue_uop_fifo.sv
// uop_fifo: in-order circular buffer of micro-ops with occupancy, full and empty
module uop_fifo
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  uop_t                   din,
  output uop_t                   dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  uop_t r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  // storage is not reset; only pointers and occupancy decide what is valid
  always_ff @(posedge clk)
    if (push) r_mem[r_wr] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wr <= r_wr + AW'(1);
      if (pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end
  assign dout  = r_mem[r_rd];
  assign count = r_count;
  assign full  = r_count == CW'(DEPTH);
  assign empty = r_count == '0;
endmodule

// File: rtl/decode_dispatch_queue.sv
// decode_dispatch_queue: picks one decoded uop per cycle, queues it in order and issues the head to its ready unit
module decode_dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int NUM_DEC  = 4,
  parameter int DEPTH    = 4,
  parameter int regWidth = REG_W,
  parameter int immWidth = IMM_W,
  parameter int NUM_FU   = dispatch_pkg::NUM_FU
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [0:NUM_DEC-1]            decEnable_i,
  input  logic [0:NUM_DEC*regWidth-1]   decReg1_i,
  input  logic [0:NUM_DEC*regWidth-1]   decReg2_i,
  input  logic [0:NUM_DEC-1]            decReg2ValOrZero_i,
  input  logic [0:NUM_DEC*immWidth-1]   decImm_i,
  input  logic [0:NUM_DEC*3-1]          decFuCode_i,
  input  logic [0:NUM_FU-1]             unitReady_i,
  output logic                          stall_o,
  output logic                          issueValid_o,
  output logic [regWidth-1:0]           issueReg1_o,
  output logic [regWidth-1:0]           issueReg2_o,
  output logic                          issueReg2ValOrZero_o,
  output logic [immWidth-1:0]           issueImm_o,
  output logic [2:0]                    issueFuCode_o,
  output logic                          multiHit_o,
  output logic                          overflow_o,
  output logic                          badUnit_o,
  output logic [$clog2(DEPTH):0]        count_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2(NUM_DEC + 1);
  uop_t w_cand;
  uop_t w_head;
  logic w_any;
  logic w_rdy;
  logic w_bad;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic [NW-1:0] w_nen;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_next;
  logic r_stall;
  logic r_valid;
  logic r_multi;
  logic r_overflow;
  logic r_bad;
  uop_t r_issue;
  // lowest-index enabled decoder wins; scanning downward lets it overwrite the others
  always_comb begin
    w_cand = '0;
    w_any = 1'b0;
    w_nen = '0;
    for (int k = NUM_DEC - 1; k >= 0; k--) begin
      w_nen = w_nen + NW'(decEnable_i[k]);
      if (decEnable_i[k]) begin
        w_any = 1'b1;
        w_cand = '{reg1: decReg1_i[k*regWidth +: regWidth], reg2: decReg2_i[k*regWidth +: regWidth],
                   reg2_zero: decReg2ValOrZero_i[k], imm: decImm_i[k*immWidth +: immWidth],
                   fu_code: decFuCode_i[k*3 +: 3]};
      end
    end
  end
  // ready of the unit named by the head; codes outside the unit range never match
  always_comb begin
    w_rdy = 1'b0;
    for (int f = 0; f < NUM_FU; f++)
      if (w_head.fu_code == 3'(f)) w_rdy = unitReady_i[f];
  end
  assign w_bad   = !w_empty && 32'(w_head.fu_code) >= NUM_FU;
  assign w_issue = !w_empty && !w_bad && w_rdy;
  assign w_pop   = w_issue || w_bad;
  assign w_push  = w_any && (!w_full || w_pop);
  assign w_next  = w_count + CW'(w_push) - CW'(w_pop);
  uop_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clock_i), .rst(reset_i), .push(w_push), .pop(w_pop), .din(w_cand),
    .dout(w_head), .count(w_count), .full(w_full), .empty(w_empty)
  );
  // registered issue port and one-cycle status pulses; stall keeps a slot free for the decoder's in-flight op
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_stall <= 1'b0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
      r_overflow <= 1'b0;
      r_bad <= 1'b0;
      r_issue <= '0;
    end else begin
      r_stall <= w_next >= CW'(DEPTH - 1);
      r_valid <= w_issue;
      r_multi <= w_nen > NW'(1);
      r_overflow <= w_any && !w_push;
      r_bad <= w_bad;
      if (w_issue) r_issue <= w_head;
    end
  end
  assign stall_o              = r_stall;
  assign issueValid_o         = r_valid;
  assign issueReg1_o          = r_issue.reg1;
  assign issueReg2_o          = r_issue.reg2;
  assign issueReg2ValOrZero_o = r_issue.reg2_zero;
  assign issueImm_o           = r_issue.imm;
  assign issueFuCode_o        = r_issue.fu_code;
  assign multiHit_o           = r_multi;
  assign overflow_o           = r_overflow;
  assign badUnit_o            = r_bad;
  assign count_o              = w_count;
endmodule

// File: tb/tb_decode_dispatch_queue.sv
// tb_decode_dispatch_queue: directed checks of select, push, issue, back-pressure and reset behaviour
module tb_decode_dispatch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [0:3]  dec_en;
  logic [0:19] dec_r1;
  logic [0:19] dec_r2;
  logic [0:3]  dec_z;
  logic [0:63] dec_imm;
  logic [0:11] dec_fu;
  logic [0:4]  ready;
  logic        stall;
  logic        iv;
  logic [4:0]  ir1;
  logic [4:0]  ir2;
  logic        iz;
  logic [15:0] iimm;
  logic [2:0]  ifu;
  logic        multi;
  logic        ovf;
  logic        bad;
  logic [2:0]  cnt;
  int n_chk = 0;
  int n_fail = 0;

  decode_dispatch_queue dut (
    .clock_i(clk), .reset_i(rst), .decEnable_i(dec_en), .decReg1_i(dec_r1), .decReg2_i(dec_r2),
    .decReg2ValOrZero_i(dec_z), .decImm_i(dec_imm), .decFuCode_i(dec_fu), .unitReady_i(ready),
    .stall_o(stall), .issueValid_o(iv), .issueReg1_o(ir1), .issueReg2_o(ir2),
    .issueReg2ValOrZero_o(iz), .issueImm_o(iimm), .issueFuCode_o(ifu), .multiHit_o(multi),
    .overflow_o(ovf), .badUnit_o(bad), .count_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [4:0] r1, input logic [4:0] r2, input logic z,
                        input logic [15:0] imm, input logic [2:0] fu);
    dec_en[k] = 1'b1;
    dec_r1[k*5 +: 5] = r1;
    dec_r2[k*5 +: 5] = r2;
    dec_z[k] = z;
    dec_imm[k*16 +: 16] = imm;
    dec_fu[k*3 +: 3] = fu;
  endtask

  initial begin
    rst = 1'b1; dec_en = '0; dec_r1 = '0; dec_r2 = '0; dec_z = '0; dec_imm = '0; dec_fu = '0; ready = '0;
    tick(); tick();
    chk("rst_count", 32'(cnt), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_valid", 32'(iv), 0);
    chk("rst_flags", {29'd0, multi, ovf, bad}, 0);
    rst = 1'b0;
    // single LdSt op through an empty queue
    set_op(0, 5'd3, 5'd1, 1'b0, 16'h0010, 3'd2);
    ready[2] = 1'b1;
    tick();
    dec_en = '0;
    chk("single_count1", 32'(cnt), 1);
    chk("single_notyet", 32'(iv), 0);
    tick();
    chk("single_valid", 32'(iv), 1);
    chk("single_fields", {ir1, ir2, iz, iimm, ifu}, {5'd3, 5'd1, 1'b0, 16'h0010, 3'd2});
    chk("single_count0", 32'(cnt), 0);
    tick();
    chk("single_drop", 32'(iv), 0);
    chk("single_hold", 32'(ir1), 3);
    // back-pressure: five FX pushes with no unit ready
    ready = '0;
    for (int i = 1; i <= 5; i++) begin
      set_op(0, 5'(i), 5'd0, 1'b1, 16'(i), 3'd0);
      tick();
      chk($sformatf("bp_count%0d", i), 32'(cnt), i > 4 ? 4 : i);
      chk($sformatf("bp_stall%0d", i), 32'(stall), i >= 3 ? 1 : 0);
      chk($sformatf("bp_ovf%0d", i), 32'(ovf), i == 5 ? 1 : 0);
    end
    dec_en = '0;
    tick();
    chk("bp_ovf_clear", 32'(ovf), 0);
    chk("bp_count_hold", 32'(cnt), 4);
    ready[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("drain_valid%0d", i), 32'(iv), 1);
      chk($sformatf("drain_reg1_%0d", i), 32'(ir1), i);
      chk($sformatf("drain_count%0d", i), 32'(cnt), 4 - i);
    end
    tick();
    chk("drain_idle", 32'(iv), 0);
    // multi-hit: decoders 1 and 2 both valid
    ready = '0;
    set_op(1, 5'd9, 5'd2, 1'b0, 16'h0009, 3'd1);
    set_op(2, 5'd10, 5'd2, 1'b0, 16'h000a, 3'd1);
    dec_en = 4'b0110;
    tick();
    dec_en = '0;
    chk("mh_pulse", 32'(multi), 1);
    chk("mh_count", 32'(cnt), 1);
    tick();
    chk("mh_clear", 32'(multi), 0);
    chk("mh_count_hold", 32'(cnt), 1);
    ready[1] = 1'b1;
    tick();
    chk("mh_issue", {31'd0, iv}, 1);
    chk("mh_reg1", 32'(ir1), 9);
    chk("mh_count0", 32'(cnt), 0);
    tick();
    chk("mh_only_one", 32'(iv), 0);
    // full queue with simultaneous push and pop
    ready = '0;
    for (int i = 11; i <= 14; i++) begin
      set_op(0, 5'(i), 5'd0, 1'b0, 16'(i), 3'd0);
      tick();
    end
    chk("full_count", 32'(cnt), 4);
    set_op(0, 5'd15, 5'd0, 1'b0, 16'd15, 3'd0);
    ready[0] = 1'b1;
    tick();
    dec_en = '0;
    chk("full_pp_valid", 32'(iv), 1);
    chk("full_pp_reg1", 32'(ir1), 11);
    chk("full_pp_count", 32'(cnt), 4);
    chk("full_pp_noovf", 32'(ovf), 0);
    for (int i = 12; i <= 15; i++) begin
      tick();
      chk($sformatf("full_drain%0d", i), 32'(ir1), i);
    end
    chk("full_empty", 32'(cnt), 0);
    // bad unit code at the head, followed by an FX op
    set_op(0, 5'd20, 5'd0, 1'b0, 16'd20, 3'd6);
    tick();
    set_op(0, 5'd21, 5'd0, 1'b0, 16'd21, 3'd0);
    tick();
    dec_en = '0;
    chk("bad_pulse", 32'(bad), 1);
    chk("bad_novalid", 32'(iv), 0);
    chk("bad_hold", 32'(ir1), 15);
    chk("bad_count", 32'(cnt), 1);
    tick();
    chk("bad_clear", 32'(bad), 0);
    chk("bad_next_valid", 32'(iv), 1);
    chk("bad_next_reg1", 32'(ir1), 21);
    // reset with three ops queued
    ready = '0;
    for (int i = 30; i <= 32; i++) begin
      set_op(0, 5'(i), 5'd4, 1'b1, 16'(i), 3'd3);
      tick();
    end
    chk("mid_count3", 32'(cnt), 3);
    chk("mid_stall", 32'(stall), 1);
    rst = 1'b1;
    ready = '1;
    tick();
    rst = 1'b0;
    dec_en = '0;
    chk("mid_rst_count", 32'(cnt), 0);
    chk("mid_rst_outs", {stall, iv, ir1, ir2, iz, iimm, ifu, multi, ovf, bad}, 0);
    tick(); tick();
    chk("mid_no_stale", 32'(iv), 0);
    chk("mid_count_after", 32'(cnt), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
